// File: rtl/regfile_wr_arbiter_if.sv
// Bundle of the two writeback requester channels, the hold control and the
// register-file write port shared by the arbiter and its surroundings.
interface regfile_wr_arbiter_if #(
    parameter int DW = 16,
    parameter int AW = 3
);
    logic                 hold;

    logic                 req0_valid;
    logic [AW-1:0]        req0_addr;
    logic [DW-1:0]        req0_data;
    logic                 req0_ready;

    logic                 req1_valid;
    logic [AW-1:0]        req1_addr;
    logic [DW-1:0]        req1_data;
    logic                 req1_ready;

    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [DW-1:0]        wr_data;
    logic [(1<<AW)-1:0]   pend_mask;
    logic                 last_grant;

    // Requesters, hold control and register-file consumer side.
    modport master (
        output hold,
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wr_en, wr_addr, wr_data, pend_mask, last_grant
    );

    // Arbiter side.
    modport slave (
        input  hold,
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wr_en, wr_addr, wr_data, pend_mask, last_grant
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-source register-file write arbiter: one-entry buffer per requester,
// round-robin grant into a registered write stage, plus a pending-write mask
// used by the control FSM for read-after-write hazard detection.
module regfile_wr_arbiter #(
    parameter int DW = 16,
    parameter int AW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int NREG = 1 << AW;

    logic [1:0]    valid_in;
    logic [AW-1:0] addr_in [2];
    logic [DW-1:0] data_in [2];

    assign valid_in   = {bus.req1_valid, bus.req0_valid};
    assign addr_in[0] = bus.req0_addr;
    assign addr_in[1] = bus.req1_addr;
    assign data_in[0] = bus.req0_data;
    assign data_in[1] = bus.req1_data;

    logic [1:0]    buf_full_q,  buf_full_d;
    logic [AW-1:0] buf_addr_q [2];
    logic [AW-1:0] buf_addr_d [2];
    logic [DW-1:0] buf_data_q [2];
    logic [DW-1:0] buf_data_d [2];
    logic          wr_en_q,      wr_en_d;
    logic [AW-1:0] wr_addr_q,    wr_addr_d;
    logic [DW-1:0] wr_data_q,    wr_data_d;
    logic          last_grant_q, last_grant_d;

    logic          grant_vld;
    logic          grant_idx;
    logic [1:0]    accept;
    logic [NREG-1:0] pend_mask;

    // Round-robin grant from buffer occupancy; hold suppresses all grants.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        grant_vld = 1'b0;
        grant_idx = 1'b0;
        if (!bus.hold) begin
            unique case (buf_full_q)
                2'b11: begin grant_vld = 1'b1; grant_idx = ~last_grant_q; end
                2'b01: begin grant_vld = 1'b1; grant_idx = 1'b0;          end
                2'b10: begin grant_vld = 1'b1; grant_idx = 1'b1;          end
                default: ;
            endcase
        end
    end

    // A buffer only loads while empty, so load and drain never coincide.
    assign accept = valid_in & ~buf_full_q;

    // Next-state for the buffers and the registered write stage.
    always_comb begin
        buf_full_d = buf_full_q | accept;
        for (int i = 0; i < 2; i++) begin
            buf_addr_d[i] = accept[i] ? addr_in[i] : buf_addr_q[i];
            buf_data_d[i] = accept[i] ? data_in[i] : buf_data_q[i];
        end
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        last_grant_d = last_grant_q;
        if (grant_vld) begin
            buf_full_d[grant_idx] = 1'b0;
            wr_en_d      = (buf_addr_q[grant_idx] != '0);
            wr_addr_d    = buf_addr_q[grant_idx];
            wr_data_d    = buf_data_q[grant_idx];
            last_grant_d = grant_idx;
        end
    end

    // Control state and write stage: cleared by synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            buf_full_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            last_grant_q <= 1'b0;
        end else begin
            buf_full_q   <= buf_full_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Buffer payload: only meaningful while its full flag is set.
    always_ff @(posedge clk) begin
        // NOTE: payload storage is deliberately not reset; the cleared full flag already discards it.
        for (int i = 0; i < 2; i++) begin
            buf_addr_q[i] <= buf_addr_d[i];
            buf_data_q[i] <= buf_data_d[i];
        end
    end

    // Pending-write mask over buffered and in-flight writes; x0 never pends.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < 2; i++) begin
            if (buf_full_q[i]) pend_mask[buf_addr_q[i]] = 1'b1;
        end
        if (wr_en_q) pend_mask[wr_addr_q] = 1'b1;
        pend_mask[0] = 1'b0;
    end

    assign bus.req0_ready = ~buf_full_q[0];
    assign bus.req1_ready = ~buf_full_q[1];
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.pend_mask  = pend_mask;
    assign bus.last_grant = last_grant_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model.
module tb_regfile_wr_arbiter;
    localparam int DW = 16;
    localparam int AW = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.DW(DW), .AW(AW)) bus ();

    regfile_wr_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model: each requester holds at most one pending write;
    // the write port shows the most recently granted write.
    bit            m_full [2];
    logic [AW-1:0] m_addr [2];
    logic [DW-1:0] m_data [2];
    bit            m_wr_en;
    logic [AW-1:0] m_wr_addr;
    logic [DW-1:0] m_wr_data;
    bit            m_lg;
    logic [DW-1:0] m_rf [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_pend();
        logic [7:0] m;
        m = '0;
        for (int r = 1; r < 8; r++) begin
            if ((m_full[0] && m_addr[0] == r) || (m_full[1] && m_addr[1] == r) ||
                (m_wr_en && m_wr_addr == r))
                m[r] = 1'b1;
        end
        return m;
    endfunction

    task automatic check_all();
        check("req0_ready", bus.req0_ready, !m_full[0]);
        check("req1_ready", bus.req1_ready, !m_full[1]);
        check("wr_en",      bus.wr_en,      m_wr_en);
        check("wr_addr",    bus.wr_addr,    m_wr_addr);
        check("wr_data",    bus.wr_data,    m_wr_data);
        check("pend_mask",  bus.pend_mask,  model_pend());
        check("last_grant", bus.last_grant, m_lg);
    endtask

    // Advance one clock: derive the model's next state from the inputs
    // currently applied, then compare all outputs shortly after the edge.
    task automatic tick();
        bit            acc [2];
        bit            v [2];
        int            g;
        logic [AW-1:0] ia [2];
        logic [DW-1:0] id [2];
        v[0] = bus.req0_valid; ia[0] = bus.req0_addr; id[0] = bus.req0_data;
        v[1] = bus.req1_valid; ia[1] = bus.req1_addr; id[1] = bus.req1_data;
        @(posedge clk);
        if (rst) begin
            m_full[0] = 0; m_full[1] = 0;
            m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0; m_lg = 0;
        end else begin
            for (int i = 0; i < 2; i++) acc[i] = v[i] && !m_full[i];
            g = -1;
            if (!bus.hold) begin
                if (m_full[0] && m_full[1]) g = m_lg ? 0 : 1;
                else if (m_full[0])         g = 0;
                else if (m_full[1])         g = 1;
            end
            m_wr_en = 0;
            if (g >= 0) begin
                m_wr_addr = m_addr[g];
                m_wr_data = m_data[g];
                m_wr_en   = (m_addr[g] != 0);
                m_lg      = (g == 1);
                m_full[g] = 0;
                if (m_wr_en) m_rf[m_wr_addr] = m_wr_data;
            end
            for (int i = 0; i < 2; i++) begin
                if (acc[i]) begin
                    m_full[i] = 1; m_addr[i] = ia[i]; m_data[i] = id[i];
                end
            end
        end
        #1;
        check_all();
    endtask

    task automatic drive(input int idx, input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (idx == 0) begin
            bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
        end else begin
            bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
        end
    endtask

    initial begin
        for (int r = 0; r < 8; r++) m_rf[r] = '0;
        m_full[0] = 0; m_full[1] = 0; m_lg = 0;
        m_wr_en = 0; m_wr_addr = '0; m_wr_data = '0;
        m_addr[0] = '0; m_addr[1] = '0; m_data[0] = '0; m_data[1] = '0;
        bus.hold = 1'b0;
        drive(0, 0, 3'd0, 16'h0);
        drive(1, 0, 3'd0, 16'h0);

        // Reset, then idle.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_ready0",  bus.req0_ready, 1'b1);
        check("rst_ready1",  bus.req1_ready, 1'b1);
        check("rst_wr_en",   bus.wr_en,      1'b0);
        check("rst_wr_addr", bus.wr_addr,    3'd0);
        check("rst_wr_data", bus.wr_data,    16'h0);
        check("rst_pend",    bus.pend_mask,  8'h00);
        check("rst_lg",      bus.last_grant, 1'b0);

        // Single write from requester 0.
        drive(0, 1, 3'd5, 16'hBEEF);
        tick();
        drive(0, 0, 3'd0, 16'h0);
        check("single_pend_E",  bus.pend_mask,  8'h20);
        check("single_ready_E", bus.req0_ready, 1'b0);
        check("single_wren_E",  bus.wr_en,      1'b0);
        tick();
        check("single_wren",  bus.wr_en,      1'b1);
        check("single_waddr", bus.wr_addr,    3'd5);
        check("single_wdata", bus.wr_data,    16'hBEEF);
        check("single_pend",  bus.pend_mask,  8'h20);
        check("single_ready", bus.req0_ready, 1'b1);
        tick();
        check("single_done", bus.wr_en, 1'b0);

        // Contention on the same register: requester 1 goes first.
        drive(0, 1, 3'd2, 16'h1111);
        drive(1, 1, 3'd2, 16'h2222);
        tick();
        drive(0, 0, 3'd0, 16'h0);
        drive(1, 0, 3'd0, 16'h0);
        check("cont_pend", bus.pend_mask, 8'h04);
        tick();
        check("cont_first_data", bus.wr_data,    16'h2222);
        check("cont_first_lg",   bus.last_grant, 1'b1);
        tick();
        check("cont_second_wren", bus.wr_en,      1'b1);
        check("cont_second_data", bus.wr_data,    16'h1111);
        check("cont_second_lg",   bus.last_grant, 1'b0);
        tick();
        check("cont_rf2", m_rf[2], 16'h1111);
        check("cont_idle", bus.wr_en, 1'b0);

        // Write to x0: consumed but never strobed.
        drive(1, 1, 3'd0, 16'hFFFF);
        tick();
        drive(1, 0, 3'd0, 16'h0);
        check("x0_pend_acc", bus.pend_mask, 8'h00);
        tick();
        check("x0_wren",  bus.wr_en,      1'b0);
        check("x0_lg",    bus.last_grant, 1'b1);
        check("x0_ready", bus.req1_ready, 1'b1);
        check("x0_pend",  bus.pend_mask,  8'h00);

        // Hold with both buffers full, then round-robin release.
        bus.hold = 1'b1;
        drive(0, 1, 3'd3, 16'hAAAA);
        drive(1, 1, 3'd6, 16'h5555);
        tick();
        drive(0, 0, 3'd0, 16'h0);
        drive(1, 0, 3'd0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_wren",   bus.wr_en,      1'b0);
            check("hold_ready0", bus.req0_ready, 1'b0);
            check("hold_ready1", bus.req1_ready, 1'b0);
            check("hold_pend",   bus.pend_mask,  8'h48);
        end
        bus.hold = 1'b0;
        tick();
        check("rel_first_addr",  bus.wr_addr, 3'd3);
        check("rel_first_wren",  bus.wr_en,   1'b1);
        tick();
        check("rel_second_addr", bus.wr_addr, 3'd6);
        check("rel_second_wren", bus.wr_en,   1'b1);
        tick();

        // Reset mid-operation discards buffered and in-flight writes.
        drive(0, 1, 3'd4, 16'h4444);
        drive(1, 1, 3'd7, 16'h7777);
        tick();
        drive(0, 0, 3'd0, 16'h0);
        drive(1, 0, 3'd0, 16'h0);
        tick();
        check("mid_wren",  bus.wr_en,      1'b1);
        check("mid_ready1", bus.req1_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_wren",   bus.wr_en,      1'b0);
        check("mid_rst_pend",   bus.pend_mask,  8'h00);
        check("mid_rst_ready0", bus.req0_ready, 1'b1);
        check("mid_rst_ready1", bus.req1_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("mid_no_ghost", bus.wr_en, 1'b0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            drive(0, $urandom_range(0, 1), AW'($urandom_range(0, 7)), DW'($urandom));
            drive(1, $urandom_range(0, 1), AW'($urandom_range(0, 7)), DW'($urandom));
            bus.hold = ($urandom_range(0, 4) == 0);
            rst      = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        bus.hold = 1'b0;
        drive(0, 0, 3'd0, 16'h0);
        drive(1, 0, 3'd0, 16'h0);
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
